// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath constants, MEM/WB control bundle and ALU opcode encodings.
package legv8_pkg;

   localparam int DATA_W     = 64;
   localparam int REG_ADDR_W = 5;
   localparam int CNT_W      = 32;

   // X31 reads as zero, so a write to it never produces a forwardable value
   localparam logic [4:0] XZR = 5'd31;

   localparam logic [3:0] ALU_AND   = 4'd0;
   localparam logic [3:0] ALU_ORR   = 4'd1;
   localparam logic [3:0] ALU_ADD   = 4'd2;
   localparam logic [3:0] ALU_SUB   = 4'd6;
   localparam logic [3:0] ALU_PASSB = 4'd7;
   localparam logic [3:0] ALU_NOR   = 4'd12;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
   } mem_wb_ctrl_t;

   function automatic mem_wb_ctrl_t gate_ctrl(input mem_wb_ctrl_t ctrl, input logic valid);
      return valid ? ctrl : '0;
   endfunction

endpackage

// File: rtl/ex_mem_stage_branch_resolve.sv
// Combinational CBZ / CBNZ / B decision from the ALU zero flag.
module branch_resolve (
   input  logic In_Valid,
   input  logic Branch,
   input  logic Branch_NZ,
   input  logic Uncond_Branch,
   input  logic Zero,
   output logic taken
);

   // Branch_NZ inverts the sense of the zero test, turning CBZ into CBNZ
   assign taken = In_Valid & (Uncond_Branch | (Branch & (Zero ^ Branch_NZ)));

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution and a saturating taken-branch counter.
// Define EXMEM_FWD_EN to expose the EX/MEM forwarding source (Fwd_Valid/Fwd_Rd/Fwd_Data).
module ex_mem_stage #(
   parameter int DATA_W     = legv8_pkg::DATA_W,
   parameter int REG_ADDR_W = legv8_pkg::REG_ADDR_W,
   parameter int CNT_W      = legv8_pkg::CNT_W
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Stall,
   input  logic                  Flush,
   input  logic                  In_Valid,
   input  logic [DATA_W-1:0]     ALU_Result,
   input  logic                  Zero,
   input  logic [DATA_W-1:0]     Read_Data2,
   input  logic [DATA_W-1:0]     Branch_Target,
   input  logic [REG_ADDR_W-1:0] Rd,
   input  logic                  Reg_Write,
   input  logic                  Mem_Read,
   input  logic                  Mem_Write,
   input  logic                  Mem_To_Reg,
   input  logic                  Branch,
   input  logic                  Branch_NZ,
   input  logic                  Uncond_Branch,
   output logic                  Out_Valid,
   output logic [DATA_W-1:0]     Out_ALU_Result,
   output logic [DATA_W-1:0]     Out_Write_Data,
   output logic [REG_ADDR_W-1:0] Out_Rd,
   output logic                  Out_Reg_Write,
   output logic                  Out_Mem_Read,
   output logic                  Out_Mem_Write,
   output logic                  Out_Mem_To_Reg,
   output logic                  PC_Src,
   output logic [DATA_W-1:0]     Out_Branch_Target,
   output logic                  Flush_Req,
   output logic [CNT_W-1:0]      Taken_Count
`ifdef EXMEM_FWD_EN
   ,
   output logic                  Fwd_Valid,
   output logic [REG_ADDR_W-1:0] Fwd_Rd,
   output logic [DATA_W-1:0]     Fwd_Data
`endif
);

   import legv8_pkg::*;

   logic                  taken;
   mem_wb_ctrl_t          ctrl_in;
   mem_wb_ctrl_t          ctrl_q;
   logic                  valid_q;
   logic                  pc_src_q;
   logic [DATA_W-1:0]     alu_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [DATA_W-1:0]     target_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic [CNT_W-1:0]      count_q;

   branch_resolve u_branch_resolve (
      .In_Valid      (In_Valid),
      .Branch        (Branch),
      .Branch_NZ     (Branch_NZ),
      .Uncond_Branch (Uncond_Branch),
      .Zero          (Zero),
      .taken         (taken)
   );

   assign ctrl_in = mem_wb_ctrl_t'{Reg_Write, Mem_Read, Mem_Write, Mem_To_Reg};

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         valid_q  <= 1'b0;
         ctrl_q   <= '0;
         pc_src_q <= 1'b0;
         alu_q    <= '0;
         wdata_q  <= '0;
         target_q <= '0;
         rd_q     <= '0;
         count_q  <= '0;
      end else if (Flush || pc_src_q) begin
         // A redirect just issued means the EX instruction is wrong-path, even under Stall
         valid_q  <= 1'b0;
         ctrl_q   <= '0;
         pc_src_q <= 1'b0;
      end else if (Stall) begin
         pc_src_q <= 1'b0;
      end else begin
         valid_q  <= In_Valid;
         ctrl_q   <= gate_ctrl(ctrl_in, In_Valid);
         pc_src_q <= taken;
         alu_q    <= ALU_Result;
         wdata_q  <= Read_Data2;
         target_q <= Branch_Target;
         rd_q     <= Rd;
         if (taken && (count_q != '1)) count_q <= count_q + CNT_W'(1);
      end
   end

   assign Out_Valid         = valid_q;
   assign Out_ALU_Result    = alu_q;
   assign Out_Write_Data    = wdata_q;
   assign Out_Rd            = rd_q;
   assign Out_Reg_Write     = ctrl_q.reg_write;
   assign Out_Mem_Read      = ctrl_q.mem_read;
   assign Out_Mem_Write     = ctrl_q.mem_write;
   assign Out_Mem_To_Reg    = ctrl_q.mem_to_reg;
   assign PC_Src            = pc_src_q;
   assign Flush_Req         = pc_src_q;
   assign Out_Branch_Target = target_q;
   assign Taken_Count       = count_q;

`ifdef EXMEM_FWD_EN
   // Loads are excluded: their value only exists after the data-memory read
   assign Fwd_Valid = valid_q & ctrl_q.reg_write & ~ctrl_q.mem_to_reg & (rd_q != REG_ADDR_W'(XZR));
   assign Fwd_Rd    = rd_q;
   assign Fwd_Data  = alu_q;
`endif

endmodule
